// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider (result = a / b), radix-2 restoring.
// Produces the exact quotient rounded to nearest-even. Subnormal operands are
// treated as zero and subnormal results are never produced.
// One division in flight at a time, using a start/busy/done handshake.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset; aborts an operation in flight
//   start      request, accepted only while busy = 0
//   a, b       dividend / divisor {sign, exp, frac}, sampled on accept
//   busy       high in UNPACK, ITER and ROUND
//   done       one-cycle pulse, result and flags valid
//   result     quotient, held until replaced by the next completed operation
//   invalid    NaN operand, 0/0 or Inf/Inf
//   div_zero   finite nonzero / 0
//   overflow   rounded exponent reached the all-ones encoding (result is Inf)
//   underflow  rounded exponent <= 0 (result flushed to signed zero)
module fp_div_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 invalid,
   output logic                 div_zero,
   output logic                 overflow,
   output logic                 underflow
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;       // signed working exponent
   localparam int QW = MAN_W + 3;       // quotient bits / iteration count
   localparam int RW = MAN_W + 2;       // partial remainder, always < 2*mb
   localparam int CW = $clog2(QW);

   localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
   localparam logic signed [EW-1:0] ONE  = EW'(1);
   localparam logic [CW-1:0]        LAST = CW'(QW - 1);
   localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-2:0]         INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;
   state_t state, state_nx;

   logic [W-1:0]           a_r, b_r;
   logic                   sign_r;
   logic signed [EW-1:0]   e_r;
   logic [MAN_W:0]         mb_r;
   logic [RW-1:0]          rem_r;
   logic [QW-1:0]          q_r;
   logic [CW-1:0]          cnt_r;

   // ---------------- operand decode (valid in UNPACK) ----------------
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     fa, fb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_u;
   logic signed [EW-1:0] e_u;

   always_comb begin
      ea     = a_r[W-2 -: EXP_W];
      eb     = b_r[W-2 -: EXP_W];
      fa     = a_r[MAN_W-1:0];
      fb     = b_r[MAN_W-1:0];
      sign_u = a_r[W-1] ^ b_r[W-1];
      // Zero exponent means zero or subnormal: both flushed to zero.
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
      e_u    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
   end

   // ---------------- special-operand resolution ----------------
   logic         sp_hit, sp_inv, sp_dz;
   logic [W-1:0] sp_res;

   always_comb begin
      sp_hit = 1'b1;
      sp_inv = 1'b0;
      sp_dz  = 1'b0;
      sp_res = '0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_res = QNAN;
         sp_inv = 1'b1;
      end else if (a_inf) begin
         sp_res = {sign_u, INF_MAG};
      end else if (b_zero) begin
         sp_res = {sign_u, INF_MAG};
         sp_dz  = 1'b1;
      end else if (a_zero || b_inf) begin
         sp_res = {sign_u, {(W-1){1'b0}}};
      end else begin
         sp_hit = 1'b0;
      end
   end

   // ---------------- one restoring step per ITER cycle ----------------
   logic [RW:0]   diff;
   logic          qbit;
   logic [RW-1:0] rem_nx;

   always_comb begin
      diff   = {1'b0, rem_r} - {2'b00, mb_r};
      qbit   = ~diff[RW];
      // diff < mb fits in RW-1 bits; a failed subtract leaves rem < mb, so
      // neither shift loses a set bit.
      rem_nx = qbit ? {diff[RW-2:0], 1'b0} : {rem_r[RW-2:0], 1'b0};
   end

   // ---------------- normalise, round-to-nearest-even, pack ----------------
   logic [MAN_W:0]       sig;
   logic                 g, s, rnd_up;
   logic [MAN_W+1:0]     sig_sum;
   logic [MAN_W-1:0]     frac;
   logic signed [EW-1:0] e_adj, e_fin;
   logic [W-1:0]         rnd_res;
   logic                 rnd_ovf, rnd_unf;

   always_comb begin
      if (q_r[QW-1]) begin
         sig   = q_r[QW-1:2];
         g     = q_r[1];
         s     = q_r[0] | (rem_r != '0);
         e_adj = e_r;
      end else begin
         sig   = q_r[QW-2:1];
         g     = q_r[0];
         s     = (rem_r != '0);
         e_adj = e_r - ONE;
      end
      rnd_up  = g & (s | sig[0]);
      sig_sum = {1'b0, sig} + {{(MAN_W+1){1'b0}}, rnd_up};
      if (sig_sum[MAN_W+1]) begin
         frac  = '0;
         e_fin = e_adj + ONE;
      end else begin
         frac  = sig_sum[MAN_W-1:0];
         e_fin = e_adj;
      end
      rnd_ovf = 1'b0;
      rnd_unf = 1'b0;
      if (!e_fin[EW-1] && (e_fin >= EMAX)) begin
         rnd_ovf = 1'b1;
         rnd_res = {sign_r, INF_MAG};
      end else if (e_fin[EW-1] || (e_fin == '0)) begin
         rnd_unf = 1'b1;
         rnd_res = {sign_r, {(W-1){1'b0}}};
      end else begin
         rnd_res = {sign_r, e_fin[EXP_W-1:0], frac};
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nx = S_UNPACK;
         S_UNPACK: begin
            busy     = 1'b1;
            state_nx = sp_hit ? S_DONE : S_ITER;
         end
         S_ITER: begin
            busy = 1'b1;
            if (cnt_r == LAST) state_nx = S_ROUND;
         end
         S_ROUND: begin
            busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = start ? S_UNPACK : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         sign_r    <= 1'b0;
         e_r       <= '0;
         mb_r      <= '0;
         rem_r     <= '0;
         q_r       <= '0;
         cnt_r     <= '0;
         result    <= '0;
         invalid   <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_r       <= a;
                  b_r       <= b;
                  invalid   <= 1'b0;
                  div_zero  <= 1'b0;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
               end
            end
            S_UNPACK: begin
               sign_r <= sign_u;
               e_r    <= e_u;
               mb_r   <= {1'b1, fb};
               rem_r  <= {1'b0, 1'b1, fa};
               q_r    <= '0;
               cnt_r  <= '0;
               if (sp_hit) begin
                  result   <= sp_res;
                  invalid  <= sp_inv;
                  div_zero <= sp_dz;
               end
            end
            S_ITER: begin
               rem_r <= rem_nx;
               q_r   <= {q_r[QW-2:0], qbit};
               cnt_r <= cnt_r + 1'b1;
            end
            S_ROUND: begin
               result    <= rnd_res;
               overflow  <= rnd_ovf;
               underflow <= rnd_unf;
            end
            default: ;
         endcase
      end
   end

endmodule
